// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and the exception FSM state type for the EX/MEM stage.
package mips_pkg;
  localparam int DATA_W_D = 32;
  localparam int REG_W_D = 5;
  localparam int EXC_CNT_W = 8;
  typedef enum logic [1:0] {RUN = 2'd0, EXC = 2'd1, WAIT_ACK = 2'd2} exc_state_e;
endpackage

// File: rtl/ex_exc_ctrl.sv
// ex_exc_ctrl: overflow-trap FSM (RUN/EXC/WAIT_ACK) with EPC and a saturating trap counter.
module ex_exc_ctrl import mips_pkg::*; #(
  parameter int DATA_W = DATA_W_D
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 accept,
  input  logic                 trap_cand,
  input  logic                 exc_ack,
  input  logic [DATA_W-1:0]    pc_plus4,
  output logic                 run,
  output logic                 trap,
  output logic                 exc_req,
  output logic                 exc_pending,
  output logic [DATA_W-1:0]    epc,
  output logic [EXC_CNT_W-1:0] exc_count
);
  exc_state_e state, state_nx;
  assign run = state == RUN;
  assign trap = run & accept & trap_cand;
  // unused encoding falls back to RUN
  always_comb state_nx = state == RUN ? (trap ? EXC : RUN) :
                         state == EXC ? WAIT_ACK :
                         state == WAIT_ACK ? (exc_ack ? RUN : WAIT_ACK) : RUN;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= RUN;
      exc_req <= 1'b0;
      exc_pending <= 1'b0;
      epc <= '0;
      exc_count <= '0;
    end else begin
      state <= state_nx;
      exc_req <= state_nx == EXC;
      exc_pending <= state_nx == WAIT_ACK;
      if (trap) begin
        epc <= pc_plus4 - DATA_W'(4);
        exc_count <= exc_count + EXC_CNT_W'(~&exc_count);
      end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch resolution and overflow-trap squashing.
module ex_mem_stage import mips_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int REG_W = REG_W_D
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic [DATA_W-1:0]    store_data,
  input  logic [REG_W-1:0]     dest_reg,
  input  logic [DATA_W-1:0]    pc_plus4,
  input  logic [DATA_W-1:0]    branch_target,
  input  logic                 branch_eq,
  input  logic                 branch_ne,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  input  logic                 mem_to_reg,
  input  logic                 ovf_trap_en,
  input  logic                 exc_ack,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_alu_result,
  output logic [DATA_W-1:0]    out_store_data,
  output logic [REG_W-1:0]     out_dest_reg,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_reg_write,
  output logic                 out_mem_to_reg,
  output logic                 branch_taken,
  output logic [DATA_W-1:0]    branch_pc,
  output logic                 exc_req,
  output logic                 exc_pending,
  output logic [DATA_W-1:0]    epc,
  output logic [EXC_CNT_W-1:0] exc_count
);
  logic run, trap, load, valid_nx, take_nx;
  // flush loads a bubble even under stall; only a real capture may trap
  assign load = ~stall | flush;
  assign valid_nx = ~flush & in_valid & run & ~trap;
  assign take_nx = valid_nx & ((branch_eq & alu_zero) | (branch_ne & ~alu_zero));
  ex_exc_ctrl #(.DATA_W(DATA_W)) u_exc (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .accept(~stall & ~flush),
    .trap_cand(in_valid & ovf_trap_en & alu_overflow),
    .exc_ack(exc_ack),
    .pc_plus4(pc_plus4),
    .run(run),
    .trap(trap),
    .exc_req(exc_req),
    .exc_pending(exc_pending),
    .epc(epc),
    .exc_count(exc_count)
  );
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      out_valid <= 1'b0;
      out_alu_result <= '0;
      out_store_data <= '0;
      out_dest_reg <= '0;
      out_mem_read <= 1'b0;
      out_mem_write <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_to_reg <= 1'b0;
      branch_taken <= 1'b0;
      branch_pc <= '0;
    end else begin
      branch_taken <= load & take_nx;
      if (load) begin
        out_valid <= valid_nx;
        out_alu_result <= alu_result;
        out_store_data <= store_data;
        out_dest_reg <= dest_reg;
        out_mem_read <= valid_nx & mem_read;
        out_mem_write <= valid_nx & mem_write;
        out_reg_write <= valid_nx & reg_write;
        out_mem_to_reg <= valid_nx & mem_to_reg;
      end
      if (load & take_nx) branch_pc <= branch_target;
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and random stimulus checked against a cycle-level behavioural model.
module tb_ex_mem_stage;
  logic Clk = 1'b0, Rst_n = 1'b0;
  logic in_valid, stall, flush, alu_zero, alu_overflow;
  logic [31:0] alu_result, store_data, pc_plus4, branch_target;
  logic [4:0] dest_reg;
  logic branch_eq, branch_ne, mem_read, mem_write, reg_write, mem_to_reg, ovf_trap_en, exc_ack;
  logic out_valid, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg;
  logic [31:0] out_alu_result, out_store_data, branch_pc, epc;
  logic [4:0] out_dest_reg;
  logic branch_taken, exc_req, exc_pending;
  logic [7:0] exc_count;
  int n_chk = 0, n_err = 0;
  int m_mode;
  logic m_valid, m_mr, m_mw, m_rw, m_m2r, m_bt;
  logic [31:0] m_alu, m_store, m_bpc, m_epc;
  logic [4:0] m_dest;
  int m_cnt;

  ex_mem_stage dut (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .store_data(store_data), .dest_reg(dest_reg), .pc_plus4(pc_plus4), .branch_target(branch_target),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .ovf_trap_en(ovf_trap_en), .exc_ack(exc_ack),
    .out_valid(out_valid), .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_dest_reg(out_dest_reg), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .exc_req(exc_req), .exc_pending(exc_pending), .epc(epc), .exc_count(exc_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_bt = 0;
    m_alu = 0; m_store = 0; m_bpc = 0; m_epc = 0; m_dest = 0; m_cnt = 0;
  endtask

  // Mode 0 = running, 1 = exception just raised, 2 = awaiting acknowledge.
  task automatic model_edge();
    bit captures, traps, ok;
    captures = !stall || flush;
    traps = m_mode == 0 && !stall && !flush && in_valid && ovf_trap_en && alu_overflow;
    m_bt = 0;
    if (captures) begin
      ok = !flush && in_valid && m_mode == 0 && !traps;
      m_valid = ok;
      m_alu = alu_result; m_store = store_data; m_dest = dest_reg;
      m_mr = ok && mem_read; m_mw = ok && mem_write; m_rw = ok && reg_write; m_m2r = ok && mem_to_reg;
      m_bt = ok && ((branch_eq && alu_zero) || (branch_ne && !alu_zero));
      if (m_bt) m_bpc = branch_target;
    end
    if (traps) begin
      m_epc = pc_plus4 - 32'd4;
      if (m_cnt < 255) m_cnt++;
    end
    if (m_mode == 0) m_mode = traps ? 1 : 0;
    else if (m_mode == 1) m_mode = 2;
    else if (exc_ack) m_mode = 0;
  endtask

  task automatic check_all();
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("alu", out_alu_result, m_alu);
    chk("store", out_store_data, m_store);
    chk("dest", 32'(out_dest_reg), 32'(m_dest));
    chk("mem_read", 32'(out_mem_read), 32'(m_mr));
    chk("mem_write", 32'(out_mem_write), 32'(m_mw));
    chk("reg_write", 32'(out_reg_write), 32'(m_rw));
    chk("mem_to_reg", 32'(out_mem_to_reg), 32'(m_m2r));
    chk("br_taken", 32'(branch_taken), 32'(m_bt));
    chk("br_pc", branch_pc, m_bpc);
    chk("exc_req", 32'(exc_req), 32'(m_mode == 1));
    chk("exc_pending", 32'(exc_pending), 32'(m_mode == 2));
    chk("epc", epc, m_epc);
    chk("exc_count", 32'(exc_count), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge Clk);
    if (Rst_n) model_edge(); else model_reset();
    #1;
    check_all();
  endtask

  task automatic clr();
    in_valid = 0; stall = 0; flush = 0; alu_zero = 0; alu_overflow = 0;
    alu_result = 0; store_data = 0; pc_plus4 = 0; branch_target = 0; dest_reg = 0;
    branch_eq = 0; branch_ne = 0; mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
    ovf_trap_en = 0; exc_ack = 0;
  endtask

  task automatic do_trap(input logic [31:0] pc);
    clr(); in_valid = 1; alu_overflow = 1; ovf_trap_en = 1; pc_plus4 = pc;
    step();
  endtask

  initial begin
    clr();
    model_reset();
    #12;
    check_all();
    @(posedge Clk); #1 Rst_n = 1;
    // basic capture
    clr(); in_valid = 1; alu_result = 32'h10; reg_write = 1; dest_reg = 5;
    step();
    chk("cap_valid", 32'(out_valid), 32'd1);
    chk("cap_alu", out_alu_result, 32'h10);
    chk("cap_rw", 32'(out_reg_write), 32'd1);
    chk("cap_dest", 32'(out_dest_reg), 32'd5);
    // branch taken / not taken
    clr(); in_valid = 1; branch_eq = 1; alu_zero = 1; branch_target = 32'h0040_0020;
    step();
    chk("br_take", 32'(branch_taken), 32'd1);
    chk("br_target", branch_pc, 32'h0040_0020);
    alu_zero = 0;
    step();
    chk("br_nottake", 32'(branch_taken), 32'd0);
    // trap, one-cycle request, pending until acknowledged
    do_trap(32'h0040_0008);
    chk("trap_valid", 32'(out_valid), 32'd0);
    chk("trap_epc", epc, 32'h0040_0004);
    chk("trap_req", 32'(exc_req), 32'd1);
    clr(); in_valid = 1; exc_ack = 1;
    step();
    chk("exc_req_drop", 32'(exc_req), 32'd0);
    chk("exc_pend", 32'(exc_pending), 32'd1);
    chk("exc_squash", 32'(out_valid), 32'd0);
    exc_ack = 0;
    step();
    chk("exc_pend_hold", 32'(exc_pending), 32'd1);
    exc_ack = 1;
    step();
    chk("ack_pend", 32'(exc_pending), 32'd0);
    clr(); in_valid = 1; alu_result = 32'h7;
    step();
    chk("post_ack_valid", 32'(out_valid), 32'd1);
    // stall holds, flush under stall bubbles
    clr(); in_valid = 1; alu_result = 32'h55; mem_write = 1;
    step();
    stall = 1; alu_result = 32'h99;
    repeat (3) step();
    chk("stall_alu", out_alu_result, 32'h55);
    chk("stall_valid", 32'(out_valid), 32'd1);
    flush = 1;
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_mw", 32'(out_mem_write), 32'd0);
    // trap beats branch
    clr(); in_valid = 1; alu_overflow = 1; ovf_trap_en = 1; branch_ne = 1; pc_plus4 = 32'h100;
    step();
    chk("conf_bt", 32'(branch_taken), 32'd0);
    chk("conf_req", 32'(exc_req), 32'd1);
    clr(); step();
    exc_ack = 1; step();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0); stall = 1'($urandom_range(0, 4) == 0);
      flush = 1'($urandom_range(0, 9) == 0); alu_zero = 1'($urandom);
      alu_overflow = 1'($urandom_range(0, 5) == 0); ovf_trap_en = 1'($urandom);
      alu_result = $urandom; store_data = $urandom; pc_plus4 = $urandom; branch_target = $urandom;
      dest_reg = 5'($urandom); branch_eq = 1'($urandom); branch_ne = 1'($urandom);
      mem_read = 1'($urandom); mem_write = 1'($urandom); reg_write = 1'($urandom);
      mem_to_reg = 1'($urandom); exc_ack = 1'($urandom_range(0, 2) == 0);
      step();
    end
    clr(); step(); exc_ack = 1; step(); step();
    // saturation
    for (int i = 0; i < 256; i++) begin
      do_trap(32'(i * 4 + 8));
      clr(); step();
      exc_ack = 1; step();
    end
    chk("sat", 32'(exc_count), 32'd255);
    // async reset while awaiting acknowledge
    do_trap(32'h0000_2000);
    clr(); step();
    chk("pre_rst_pend", 32'(exc_pending), 32'd1);
    #2 Rst_n = 0;
    #1 model_reset();
    check_all();
    chk("rst_pend", 32'(exc_pending), 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_cnt", 32'(exc_count), 32'd0);
    step();
    #1 Rst_n = 1;
    clr(); in_valid = 1; alu_result = 32'h3;
    step();
    chk("rst_run", 32'(out_valid), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have the port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port Rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have the input ports in_valid (1), stall (1), flush (1), alu_result (DATA_W), alu_zero (1) and alu_overflow (1), from the EX ALU.
REQ-006 SHALL have the input ports store_data (DATA_W), dest_reg (REG_W), pc_plus4 (DATA_W) and branch_target (DATA_W).
REQ-007 SHALL have the 1-bit control inputs branch_eq, branch_ne, mem_read, mem_write, reg_write, mem_to_reg, ovf_trap_en and exc_ack.
REQ-008 SHALL have the registered outputs out_valid, out_alu_result, out_store_data, out_dest_reg, out_mem_read, out_mem_write, out_reg_write and out_mem_to_reg.
REQ-009 SHALL have the outputs branch_taken (1), branch_pc (DATA_W), exc_req (1), exc_pending (1), epc (DATA_W) and exc_count (8), all registered.

Function
REQ-010 SHALL capture all inputs on a Clk edge when stall=0; stall=1 holds every pipeline output unchanged.
REQ-011 SHALL load a bubble (out_valid=0) on flush=1; flush overrides stall and in_valid.
REQ-012 SHALL force out_mem_read, out_mem_write, out_reg_write and out_mem_to_reg to 0 whenever out_valid=0.
REQ-013 SHALL compute branch_taken one cycle after capture as in_valid & ((branch_eq & alu_zero) | (branch_ne & ~alu_zero)).
REQ-014 SHALL register branch_pc from branch_target when branch_taken is set.
REQ-015 SHALL clear branch_taken on any cycle that does not capture a valid branch, including bubbles.
REQ-016 SHALL implement an FSM with states RUN, EXC and WAIT_ACK.
REQ-017 SHALL, in state RUN, trap on a capturing edge with in_valid & ovf_trap_en & alu_overflow.
REQ-018 SHALL, on a trap: squash the instruction (out_valid=0), load epc with pc_plus4-4 (mod 2^DATA_W), increment exc_count saturating at 255, and go to EXC.
REQ-019 SHALL not trap when ovf_trap_en=0; the overflowed result passes through with out_valid=1.
REQ-020 SHALL give a trap priority over a branch in the same instruction: branch_taken=0.
REQ-021 SHALL assert exc_req for exactly one cycle in EXC, then move unconditionally to WAIT_ACK.
REQ-022 SHALL assert exc_pending in WAIT_ACK; exc_ack=1 there returns the FSM to RUN on the next edge.
REQ-023 SHALL ignore exc_ack in RUN and in EXC.
REQ-024 SHALL squash every instruction captured in EXC or WAIT_ACK to a bubble, with epc and exc_count held.
REQ-025 SHALL advance the FSM regardless of stall, and SHALL not trap while stall=1 (no capture takes place).

Reset
REQ-026 SHALL, while Rst_n=0: set FSM=RUN and all outputs 0, including epc, exc_count, exc_req and exc_pending.
REQ-027 SHALL discard any in-flight trap on reset mid-EXC/WAIT_ACK; the first edge after release behaves as RUN.

Structure
REQ-028 SHALL place the FSM state enum (RUN=0, EXC=1, WAIT_ACK=2), DATA_W/REG_W defaults and the exc_count width in the shared package mips_pkg.
REQ-029 SHALL implement the FSM, epc and exc_count in one sub-module, ex_exc_ctrl; the pipeline register stays in ex_mem_stage.

Verification
REQ-030 SHALL cover the capture case: in_valid=1, alu_result=0x0000_0010, reg_write=1, dest_reg=5 -> next cycle out_valid=1, out_alu_result=0x10, out_reg_write=1, out_dest_reg=5.
REQ-031 SHALL cover the branch case: branch_eq=1, alu_zero=1, branch_target=0x0040_0020 -> branch_taken=1 and branch_pc=0x0040_0020; alu_zero=0 -> branch_taken=0.
REQ-032 SHALL cover the trap case: pc_plus4=0x0040_0008, alu_overflow=1, ovf_trap_en=1 -> out_valid=0, epc=0x0040_0004, exc_req pulses for one cycle, then exc_pending=1 until exc_ack, after which the next instruction passes.
REQ-033 SHALL cover stall versus flush: stall=1 for 3 cycles holds the outputs; stall=1 with flush=1 -> out_valid=0 and all control outputs 0.
REQ-034 SHALL cover the trap/branch conflict: overflow plus branch_ne=1, alu_zero=0, trap enabled -> branch_taken=0 and exc_req=1.
REQ-035 SHALL cover saturation and reset: 256 traps leave exc_count=255; Rst_n low during WAIT_ACK clears exc_pending, epc and exc_count immediately.
